// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, issues single-outstanding reads
// to instruction memory and buffers returned words for decode; taken branches redirect.
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] pc_current
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [15:0]   buf_instr [DEPTH];
  logic [15:0]   buf_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          issue;

  assign dec_valid  = (count != '0);
  assign dec_instr  = dec_valid ? buf_instr[rd_ptr] : '0;
  assign pc_current = dec_valid ? buf_pc[rd_ptr]    : '0;

  // A new read may only leave when nothing remains outstanding after this edge,
  // so the outstanding term of the fill check is always zero here.
  always_comb begin
    push       = (state == WAIT) && imem_rvalid && !branch_taken;
    pop        = dec_valid && dec_ready && !branch_taken;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
    can_issue = (state == IDLE) || ((state == WAIT) && imem_rvalid);
    issue     = can_issue && !halt && !branch_taken && (count_next < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      imem_req <= 1'b0;
      if (branch_taken) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= branch_target;
        if (state == WAIT) begin
          state <= imem_rvalid ? IDLE : DROP;
        end
      end else begin
        count <= count_next;
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + 16'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        unique case (state)
          IDLE: begin
            if (issue) begin
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc + 16'd1;
              end else begin
                state <= IDLE;
              end
            end
          end
          DROP: begin
            if (imem_rvalid) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory responder with programmable latency
// feeds a queue of expected decode entries that the DUT output is checked against.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst0_n, rst1_n;
  logic        halt, branch_taken, dec_ready;
  logic [15:0] branch_target;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  logic        req0, req1, dv0, dv1;
  logic [15:0] addr0, addr1, di0, di1, pc0, pc1;

  bit          sel;
  logic        o_req, o_dv;
  logic [15:0] o_addr, o_di, o_pc;

  assign o_req  = sel ? req1  : req0;
  assign o_dv   = sel ? dv1   : dv0;
  assign o_addr = sel ? addr1 : addr0;
  assign o_di   = sel ? di1   : di0;
  assign o_pc   = sel ? pc1   : pc0;

  fetch_sequencer #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst0_n), .halt(halt), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(req0), .imem_addr(addr0),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dv0),
    .dec_ready(dec_ready), .dec_instr(di0), .pc_current(pc0)
  );

  fetch_sequencer #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst_n(rst1_n), .halt(halt), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dv1),
    .dec_ready(dec_ready), .dec_instr(di1), .pc_current(pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          lat;
  int          pops, reqs;
  logic [31:0] q[$];
  logic [15:0] pop_log[$];
  logic        pend, pend_stale;
  int          pend_cnt;
  logic [15:0] pend_addr;
  logic [15:0] req_exp;
  logic        req_flag;
  logic [15:0] last_req_addr;
  logic [15:0] last_pop_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return m ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input bit which);
    q.delete();
    pop_log.delete();
    pend        = 1'b0;
    pend_stale  = 1'b0;
    pend_cnt    = 0;
    imem_rvalid = 1'b0;
    req_exp     = which ? 16'hFFFE : 16'h0000;
    pops        = 0;
    reqs        = 0;
    req_flag    = 1'b0;
  endtask

  // One clock cycle: check outputs and respond as memory at the negedge, return at posedge+1.
  task automatic step();
    logic [31:0] e;
    bit          new_req;
    @(negedge clk);
    new_req  = 1'b0;
    req_flag = 1'b0;
    chk("dec_valid", o_dv, (q.size() != 0));
    if (!o_dv) begin
      chk("dec_instr_empty", o_di, 16'h0);
      chk("pc_current_empty", o_pc, 16'h0);
    end
    if (o_dv && dec_ready && !branch_taken) begin
      chk("pop_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_current", o_pc, e[31:16]);
        chk("dec_instr", o_di, e[15:0]);
      end
      pops++;
      last_pop_pc = o_pc;
      pop_log.push_back(o_pc);
    end
    if (o_req) begin
      chk("imem_addr", o_addr, req_exp);
      req_exp       = req_exp + 16'd1;
      reqs++;
      new_req       = 1'b1;
      req_flag      = 1'b1;
      last_req_addr = o_addr;
    end
    imem_rvalid = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
        if (!pend_stale && !branch_taken) q.push_back({pend_addr, mem_word(pend_addr)});
      end else begin
        pend_cnt--;
      end
    end
    if (new_req) begin
      chk("one_outstanding", pend, 0);
      pend       = 1'b1;
      pend_cnt   = lat;
      pend_addr  = o_addr;
      pend_stale = 1'b0;
    end
    if (branch_taken) begin
      q.delete();
      if (pend) pend_stale = 1'b1;
      req_exp = branch_target;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input bit which);
    sel    = which;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    #1;
    chk("rst_imem_req", o_req, 0);
    chk("rst_imem_addr", o_addr, 16'h0);
    chk("rst_dec_valid", o_dv, 0);
    chk("rst_dec_instr", o_di, 16'h0);
    chk("rst_pc_current", o_pc, 16'h0);
    clear_model(which);
    repeat (2) step();
    if (which) rst1_n = 1'b1;
    else       rst0_n = 1'b1;
  endtask

  initial begin
    int n;
    rst0_n = 1'b0; rst1_n = 1'b0;
    halt = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    dec_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0;
    lat = 1; sel = 1'b0;
    clear_model(1'b0);
    @(posedge clk); #1;

    // Straight-line fetch, latency 1
    reset_dut(1'b0);
    repeat (20) step();
    chk("A_pops_min5", (pops >= 5), 1);

    // Backpressure: DEPTH=2 fills with exactly two requests
    dec_ready = 1'b0;
    reset_dut(1'b0);
    repeat (20) step();
    chk("B_reqs_full", reqs, 2);
    chk("B_dec_valid_full", o_dv, 1);
    chk("B_head_pc", o_pc, 16'h0000);
    reqs = 0; pops = 0;
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    repeat (10) step();
    chk("B_one_pop", pops, 1);
    chk("B_refill_one_req", reqs, 1);
    chk("B_head_after_pop", o_pc, 16'h0001);

    // Branch while read of 0x0005 outstanding, latency 3
    dec_ready = 1'b1; lat = 3;
    reset_dut(1'b0);
    n = 0;
    while (n < 300 && !(req_flag && last_req_addr == 16'h0005)) begin step(); n++; end
    chk("C_reached_0005", (req_flag && last_req_addr == 16'h0005), 1);
    branch_taken = 1'b1; branch_target = 16'h010B;
    step();
    branch_taken = 1'b0;
    pops = 0; n = 0;
    while (n < 50 && pops == 0) begin step(); n++; end
    chk("C_pop_seen", (pops != 0), 1);
    chk("C_first_pc_target", last_pop_pc, 16'h010B);
    repeat (10) step();

    // Branch coincident with imem_rvalid, latency 1
    lat = 1;
    reset_dut(1'b0);
    n = 0;
    while (n < 50 && !req_flag) begin step(); n++; end
    chk("D_first_req", req_flag, 1);
    branch_taken = 1'b1; branch_target = 16'h0200;
    step();
    branch_taken = 1'b0;
    chk("D_empty_after", o_dv, 0);
    n = 0;
    step();
    while (n < 50 && !req_flag) begin step(); n++; end
    chk("D_req_seen", req_flag, 1);
    chk("D_req_target", last_req_addr, 16'h0200);
    repeat (6) step();

    // halt: no issue while high, resume next cycle, outstanding read completes
    halt = 1'b1; lat = 3;
    reset_dut(1'b0);
    repeat (8) step();
    chk("E_halt_noreq", reqs, 0);
    halt = 1'b0;
    step();
    chk("E_not_yet", reqs, 0);
    halt = 1'b1;
    step();
    chk("E_resume_req", reqs, 1);
    n = 0;
    while (n < 20 && pops == 0) begin step(); n++; end
    chk("E_outstanding_buffered", pops, 1);
    repeat (6) step();
    chk("E_halt_no_more", reqs, 1);
    halt = 1'b0;

    // DEPTH=4, RESET_PC=FFFE: wrap through 0000
    lat = 1;
    reset_dut(1'b1);
    n = 0;
    while (n < 100 && pops < 4) begin step(); n++; end
    chk("W_pops4", (pops >= 4), 1);
    if (pop_log.size() >= 4) begin
      chk("W_pc0", pop_log[0], 16'hFFFE);
      chk("W_pc1", pop_log[1], 16'hFFFF);
      chk("W_pc2", pop_log[2], 16'h0000);
      chk("W_pc3", pop_log[3], 16'h0001);
    end

    // Async reset in WAIT with two buffered entries
    lat = 3; dec_ready = 1'b0;
    reset_dut(1'b1);
    n = 0;
    while (n < 100 && !(q.size() == 2 && o_req)) begin step(); n++; end
    chk("F_reached_wait2", (q.size() == 2 && o_req && o_dv), 1);
    rst1_n = 1'b0;
    #1;
    chk("F_rst_dec_valid", o_dv, 0);
    chk("F_rst_imem_req", o_req, 0);
    clear_model(1'b1);
    repeat (2) step();
    rst1_n = 1'b1;
    n = 0;
    while (n < 20 && !req_flag) begin step(); n++; end
    chk("F_req_after_release", req_flag, 1);
    chk("F_addr_reset_pc", last_req_addr, 16'hFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
